simon_playback_ctrl: RTL and testbench
======================================

Name: simon_playback_ctrl

Overview:
Sequencer that plays the stored Simon colour pattern back to the player before each input phase. The game state machine pulses Start_Play with the packed 30-bit colour vector and the current round length. The block then steps through the colours one at a time, driving the four colour LEDs and a colour code to the VGA path. Each colour is shown for a fixed on-time followed by a blank gap, and the block reports completion with a Done pulse.

Parameters:
SEQ_LEN, 10, maximum number of colours in the packed vector
CODE_W, 3, bits per colour code (1=RED, 2=BLUE, 3=YELLOW, 4=GREEN, 0=blank)
ON_CYCLES, 50000000, clock cycles each colour is lit (must be >=1)
OFF_CYCLES, 25000000, clock cycles of blank gap after each colour (must be >=1)

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
Start_Play  in  1  single-cycle request to begin playback; accepted only in IDLE
Abort  in  1  level; forces return to IDLE (e.g. ON switch dropped)
Num_Colors  in  4  number of colours to play, valid range 1..SEQ_LEN
Colors  in  SEQ_LEN*CODE_W  packed sequence; colour i at bits [CODE_W*i +: CODE_W]
Busy  out  1  high while playback is in progress (SHOW, GAP, DONE)
Done  out  1  one-cycle pulse when the last gap completes
Err  out  1  one-cycle pulse on a rejected start or an invalid colour code
Color_Out  out  3  current colour code; 0 during the gap and when idle
Led_Red, Led_Blue, Led_Yellow, Led_Green  out  1 each  one-hot decode of Color_Out
Index  out  4  index of the colour currently shown (0-based)

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-low on Reset_n. Reset has priority over every other input.
- Reset values: state=IDLE, Busy=0, Done=0, Err=0, Color_Out=0, all LEDs=0, Index=0, internal timer=0, latched vector=0.
- States: IDLE, SHOW, GAP, DONE.
- IDLE, Start_Play=1 with Num_Colors in 1..SEQ_LEN:
  - Latch Colors and Num_Colors; later input changes are ignored for the rest of playback.
  - Index=0, timer=0; next state SHOW.
  - First colour is visible on the edge after Start_Play is sampled.
- IDLE, Start_Play=1 with Num_Colors=0 or >SEQ_LEN: Err pulses for one cycle; the block stays in IDLE.
- SHOW:
  - Color_Out = latched code at Index. LEDs are the one-hot decode of that code.
  - Timer counts 0..ON_CYCLES-1; at terminal count, timer clears and state goes to GAP.
  - SHOW lasts exactly ON_CYCLES cycles.
  - A code of 0 or >4: LEDs all 0, Color_Out passes the raw code through, Err pulses on the first SHOW cycle. Timing is unchanged.
- GAP:
  - Color_Out=0, LEDs=0. Lasts exactly OFF_CYCLES cycles.
  - At terminal count: if Index==Num_Colors-1, go to DONE; otherwise Index+1 and go to SHOW.
- DONE: Done=1 and Busy=1 for exactly one cycle, then IDLE.
- Total from accepted start to Done pulse: Num_Colors*(ON_CYCLES+OFF_CYCLES) cycles; Done occupies the following cycle.
- Start_Play outside IDLE, including the DONE cycle, is ignored; no Err.
- Abort=1 in any state: next state IDLE, outputs return to reset values, no Done pulse.
- Abort=1 and Start_Play=1 together in IDLE: Abort wins and the start is dropped.
- Timer width is $clog2(max(ON_CYCLES,OFF_CYCLES)). Timer and Index never wrap, because terminal counts always leave the state.

Decomposition:
- Shared package simon_pkg holds:
  - colour code constants RED=1, BLUE=2, YELLOW=3, GREEN=4, BLANK=0
  - CODE_W and SEQ_LEN
  - playback state encoding, one-hot 4-bit, consistent with the game state machine's one-hot style
- One sub-module, simon_color_decode: combinational 3-bit code to four LEDs plus a valid flag. It is reused by the input-side logic.

Test Plan (ON_CYCLES=4, OFF_CYCLES=2):
- Reset_n=0 for 2 cycles with Start_Play=1 -> all outputs 0; state stays IDLE after release.
- Colors=...001_011_010 (colours 2,3,1), Num_Colors=3, one Start_Play pulse -> Color_Out sequence 2x4, 0x2, 3x4, 0x2, 1x4, 0x2. Then Done=1 for 1 cycle at cycle 19 after start. Busy high cycles 1..19; LEDs match (Blue, Yellow, Red).
- Num_Colors=0, then Num_Colors=11, each with Start_Play -> Err one-cycle pulse each time, Busy stays 0, no Done.
- Start playback with Num_Colors=2, assert Abort during the second SHOW -> next cycle Busy=0, Color_Out=0, no Done ever. A following Start_Play is accepted normally.
- Playback of 1 colour with code 0 -> Err pulse on first SHOW cycle, LEDs 0 for 6 cycles, Done pulses at cycle 7.
- Change Colors and Num_Colors mid-playback and pulse Start_Play again while Busy -> original sequence plays unchanged; exactly one Done.

Source files
------------

// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
// Shared definitions for the Simon game blocks: colour codes, sequence
// geometry and the one-hot playback state encoding. A small helper checks
// whether a requested round length is playable.
// -----------------------------------------------------------------------------
package simon_pkg;

    // Sequence geometry: up to SEQ_LEN colours of CODE_W bits each
    localparam int CODE_W  = 3;
    localparam int SEQ_LEN = 10;

    // Colour codes carried on the 3-bit colour bus
    localparam logic [2:0] CLR_BLANK  = 3'd0;
    localparam logic [2:0] CLR_RED    = 3'd1;
    localparam logic [2:0] CLR_BLUE   = 3'd2;
    localparam logic [2:0] CLR_YELLOW = 3'd3;
    localparam logic [2:0] CLR_GREEN  = 3'd4;

    // Playback states, one-hot like the game state machine
    localparam logic [3:0] PB_IDLE = 4'b0001;
    localparam logic [3:0] PB_SHOW = 4'b0010;
    localparam logic [3:0] PB_GAP  = 4'b0100;
    localparam logic [3:0] PB_DONE = 4'b1000;

    // A round length is playable when it is in 1..max_n
    function automatic logic count_ok(input logic [3:0] n, input int max_n);
        return (n != 4'd0) && (int'(n) <= max_n);
    endfunction

endpackage

// File: rtl/simon_color_decode.sv
// -----------------------------------------------------------------------------
// simon_color_decode
// Combinational decode of a 3-bit colour code into the four colour LEDs.
// Shared by the playback sequencer and the player input logic.
//   code        in  3  colour code (1=red, 2=blue, 3=yellow, 4=green)
//   led_red..   out 1  one-hot LED drive, all low for blank/unknown codes
//   valid       out 1  high when the code names a real colour
// -----------------------------------------------------------------------------
module simon_color_decode
    import simon_pkg::*;
(
    input  logic [2:0] code,
    output logic       led_red,
    output logic       led_blue,
    output logic       led_yellow,
    output logic       led_green,
    output logic       valid
);

    // One-hot decode; codes 0 and 5..7 light nothing and are flagged invalid
    always_comb begin
        led_red    = 1'b0;
        led_blue   = 1'b0;
        led_yellow = 1'b0;
        led_green  = 1'b0;
        case (code)
            CLR_RED:    led_red    = 1'b1;
            CLR_BLUE:   led_blue   = 1'b1;
            CLR_YELLOW: led_yellow = 1'b1;
            CLR_GREEN:  led_green  = 1'b1;
            default: begin
                led_red    = 1'b0;
                led_blue   = 1'b0;
                led_yellow = 1'b0;
                led_green  = 1'b0;
            end
        endcase
        valid = led_red | led_blue | led_yellow | led_green;
    end

endmodule

// File: rtl/simon_playback_ctrl.sv
// -----------------------------------------------------------------------------
// simon_playback_ctrl
// Plays the stored Simon colour pattern back to the player. A Start_Play pulse
// in IDLE latches the packed colour vector and round length; each colour is
// shown for ON_CYCLES clocks followed by an OFF_CYCLES blank gap, and a Done
// pulse marks the end of the sequence. All outputs are registered and are
// computed from the next-state values, so the first colour appears on the
// edge that samples Start_Play.
//   Clk, Reset_n        clock, synchronous active-low reset
//   Start_Play          start request (IDLE only)
//   Abort               level, returns to IDLE with outputs cleared
//   Num_Colors, Colors  round length and packed colour sequence
//   Busy, Done, Err     status: playing, end-of-sequence pulse, error pulse
//   Color_Out, Led_*    current colour code and its one-hot LED decode
//   Index               0-based position of the colour being shown
// -----------------------------------------------------------------------------
module simon_playback_ctrl
    import simon_pkg::*;
#(
    parameter int ON_CYCLES  = 50000000,
    parameter int OFF_CYCLES = 25000000
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Start_Play,
    input  logic                       Abort,
    input  logic [3:0]                 Num_Colors,
    input  logic [SEQ_LEN*CODE_W-1:0]  Colors,
    output logic                       Busy,
    output logic                       Done,
    output logic                       Err,
    output logic [2:0]                 Color_Out,
    output logic                       Led_Red,
    output logic                       Led_Blue,
    output logic                       Led_Yellow,
    output logic                       Led_Green,
    output logic [3:0]                 Index
);

    localparam int COLORS_W = SEQ_LEN * CODE_W;
    localparam int TMR_MAX  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);

    logic [3:0]          state_r,  state_nxt_s;
    logic [TMR_W-1:0]    timer_r,  timer_nxt_s;
    logic [3:0]          index_r,  index_nxt_s;
    logic [3:0]          num_r,    num_nxt_s;
    logic [COLORS_W-1:0] colors_r, colors_nxt_s;
    logic                rej_start_s;
    logic                enter_show_s;
    logic [2:0]          show_code_s;
    logic                led_red_s, led_blue_s, led_yellow_s, led_green_s;
    logic                code_valid_s;

    // Next-state logic for the playback sequencer and its latched inputs
    always_comb begin
        state_nxt_s  = state_r;
        timer_nxt_s  = timer_r;
        index_nxt_s  = index_r;
        num_nxt_s    = num_r;
        colors_nxt_s = colors_r;
        rej_start_s  = 1'b0;
        if (Abort) begin
            // Abort dominates everything, including a simultaneous start
            state_nxt_s  = PB_IDLE;
            timer_nxt_s  = '0;
            index_nxt_s  = 4'd0;
            num_nxt_s    = 4'd0;
            colors_nxt_s = '0;
        end else begin
            case (state_r)
                PB_IDLE: begin
                    if (Start_Play) begin
                        if (count_ok(Num_Colors, SEQ_LEN)) begin
                            state_nxt_s  = PB_SHOW;
                            timer_nxt_s  = '0;
                            index_nxt_s  = 4'd0;
                            num_nxt_s    = Num_Colors;
                            colors_nxt_s = Colors;
                        end else begin
                            rej_start_s = 1'b1;
                        end
                    end else begin
                        state_nxt_s = PB_IDLE;
                    end
                end
                PB_SHOW: begin
                    if (timer_r == ON_LAST) begin
                        timer_nxt_s = '0;
                        state_nxt_s = PB_GAP;
                    end else begin
                        timer_nxt_s = timer_r + TMR_W'(1);
                    end
                end
                PB_GAP: begin
                    if (timer_r == OFF_LAST) begin
                        timer_nxt_s = '0;
                        if (index_r == (num_r - 4'd1)) begin
                            state_nxt_s = PB_DONE;
                        end else begin
                            index_nxt_s = index_r + 4'd1;
                            state_nxt_s = PB_SHOW;
                        end
                    end else begin
                        timer_nxt_s = timer_r + TMR_W'(1);
                    end
                end
                PB_DONE: begin
                    state_nxt_s = PB_IDLE;
                end
                default: begin
                    // Illegal encoding: recover to a clean idle
                    state_nxt_s  = PB_IDLE;
                    timer_nxt_s  = '0;
                    index_nxt_s  = 4'd0;
                    num_nxt_s    = 4'd0;
                    colors_nxt_s = '0;
                end
            endcase
        end
    end

    // Colour to present next cycle; blank outside SHOW
    always_comb begin
        if (state_nxt_s == PB_SHOW) begin
            show_code_s = colors_nxt_s[CODE_W*int'(index_nxt_s) +: CODE_W];
        end else begin
            show_code_s = CLR_BLANK;
        end
        enter_show_s = (state_nxt_s == PB_SHOW) && (state_r != PB_SHOW);
    end

    simon_color_decode u_decode (
        .code       (show_code_s),
        .led_red    (led_red_s),
        .led_blue   (led_blue_s),
        .led_yellow (led_yellow_s),
        .led_green  (led_green_s),
        .valid      (code_valid_s)
    );

    // State, latched sequence and registered outputs
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r    <= PB_IDLE;
            timer_r    <= '0;
            index_r    <= 4'd0;
            num_r      <= 4'd0;
            colors_r   <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Err        <= 1'b0;
            Color_Out  <= CLR_BLANK;
            Led_Red    <= 1'b0;
            Led_Blue   <= 1'b0;
            Led_Yellow <= 1'b0;
            Led_Green  <= 1'b0;
            Index      <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            timer_r    <= timer_nxt_s;
            index_r    <= index_nxt_s;
            num_r      <= num_nxt_s;
            colors_r   <= colors_nxt_s;
            Busy       <= (state_nxt_s != PB_IDLE);
            Done       <= (state_nxt_s == PB_DONE);
            // Bad codes are flagged once, on the first cycle they are shown
            Err        <= rej_start_s | (enter_show_s & ~code_valid_s);
            Color_Out  <= show_code_s;
            Led_Red    <= led_red_s;
            Led_Blue   <= led_blue_s;
            Led_Yellow <= led_yellow_s;
            Led_Green  <= led_green_s;
            Index      <= index_nxt_s;
        end
    end

endmodule

// File: tb/tb_simon_playback_ctrl.sv
module tb_simon_playback_ctrl;

    localparam int ON_C  = 4;
    localparam int OFF_C = 2;

    typedef struct packed {
        logic [2:0] color;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] leds;
        logic [3:0] idx;
        logic       chk_idx;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start_Play;
    logic        Abort;
    logic [3:0]  Num_Colors;
    logic [29:0] Colors;
    logic        Busy, Done, Err;
    logic [2:0]  Color_Out;
    logic        Led_Red, Led_Blue, Led_Yellow, Led_Green;
    logic [3:0]  Index;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    simon_playback_ctrl #(.ON_CYCLES(ON_C), .OFF_CYCLES(OFF_C)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start_Play (Start_Play),
        .Abort      (Abort),
        .Num_Colors (Num_Colors),
        .Colors     (Colors),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err),
        .Color_Out  (Color_Out),
        .Led_Red    (Led_Red),
        .Led_Blue   (Led_Blue),
        .Led_Yellow (Led_Yellow),
        .Led_Green  (Led_Green),
        .Index      (Index)
    );

    function automatic logic [3:0] leds_of(input logic [2:0] c);
        case (c)
            3'd1:    return 4'b1000;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b0010;
            3'd4:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rec(input logic [2:0] color, input logic busy, input logic done,
                            input logic err, input logic [3:0] idx, input logic chk_idx);
        exp_t e;
        e.color   = color;
        e.busy    = busy;
        e.done    = done;
        e.err     = err;
        e.leds    = leds_of(color);
        e.idx     = idx;
        e.chk_idx = chk_idx;
        q.push_back(e);
    endtask

    // Expected per-cycle trace of a full playback, plus the idle cycle after Done
    task automatic push_trace(input logic [29:0] cols, input int n);
        logic [2:0] code;
        for (int i = 0; i < n; i++) begin
            code = cols[3*i +: 3];
            for (int k = 0; k < ON_C; k++)
                push_rec(code, 1'b1, 1'b0, (k == 0) && ((code == 3'd0) || (code > 3'd4)), 4'(i), 1'b1);
            for (int k = 0; k < OFF_C; k++)
                push_rec(3'd0, 1'b1, 1'b0, 1'b0, 4'(i), 1'b1);
        end
        push_rec(3'd0, 1'b1, 1'b1, 1'b0, 4'(n - 1), 1'b1);
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic check_next(input string tag);
        exp_t e;
        checks++;
        assert (q.size() > 0) else begin
            errors++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ".color"}, {5'd0, Color_Out}, {5'd0, e.color});
            chk({tag, ".busy"},  {7'd0, Busy},      {7'd0, e.busy});
            chk({tag, ".done"},  {7'd0, Done},      {7'd0, e.done});
            chk({tag, ".err"},   {7'd0, Err},       {7'd0, e.err});
            chk({tag, ".leds"},  {4'd0, Led_Red, Led_Blue, Led_Yellow, Led_Green}, {4'd0, e.leds});
            if (e.chk_idx)
                chk({tag, ".index"}, {4'd0, Index}, {4'd0, e.idx});
        end
    endtask

    task automatic start_play(input logic [29:0] cols, input logic [3:0] n);
        Colors     = cols;
        Num_Colors = n;
        Start_Play = 1'b1;
        step();
        Start_Play = 1'b0;
    endtask

    task automatic run_rest(input string tag);
        check_next(tag);
        while (q.size() > 0) begin
            step();
            check_next(tag);
        end
    endtask

    initial begin
        // Reset held with Start_Play asserted
        Reset_n = 1'b0; Start_Play = 1'b1; Abort = 1'b0;
        Num_Colors = 4'd3; Colors = {21'd0, 3'd1, 3'd3, 3'd2};
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(); check_next("reset");
        step(); check_next("reset");
        Reset_n = 1'b1; Start_Play = 1'b0;
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step(); check_next("post_reset");
        step(); check_next("post_reset");

        // Three colours: blue, yellow, red
        push_trace({21'd0, 3'd1, 3'd3, 3'd2}, 3);
        start_play({21'd0, 3'd1, 3'd3, 3'd2}, 4'd3);
        run_rest("play3");

        // Rejected round lengths
        push_rec(3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        start_play({21'd0, 3'd1, 3'd3, 3'd2}, 4'd0);
        run_rest("rej0");
        push_rec(3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        start_play({21'd0, 3'd1, 3'd3, 3'd2}, 4'd11);
        run_rest("rej11");

        // Abort during the second SHOW
        push_trace({24'd0, 3'd1, 3'd4}, 2);
        start_play({24'd0, 3'd1, 3'd4}, 4'd2);
        check_next("abort_pre");
        for (int c = 2; c <= ON_C + OFF_C + 2; c++) begin
            step();
            check_next("abort_pre");
        end
        q.delete();
        Abort = 1'b1;
        step();
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        check_next("abort");
        Abort = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            check_next("abort_idle");
        end
        push_trace({27'd0, 3'd4}, 1);
        start_play({27'd0, 3'd4}, 4'd1);
        run_rest("after_abort");

        // Abort and Start_Play together in IDLE
        Abort = 1'b1;
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        start_play({27'd0, 3'd2}, 4'd1);
        Abort = 1'b0;
        check_next("abort_start");
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        step();
        check_next("abort_start_idle");

        // Single blank colour: Err on first SHOW cycle, Done at cycle 7
        push_trace(30'd0, 1);
        start_play(30'd0, 4'd1);
        run_rest("blank");

        // Inputs changed and Start_Play pulsed while busy, incl. the DONE cycle
        push_trace({24'd0, 3'd2, 3'd1}, 2);
        start_play({24'd0, 3'd2, 3'd1}, 4'd2);
        check_next("latch");
        for (int c = 2; c <= 2 * (ON_C + OFF_C) + 2; c++) begin
            if (c == 3) begin
                Colors = {15'd0, 3'd4, 3'd4, 3'd4, 3'd3, 3'd3};
                Num_Colors = 4'd5;
                Start_Play = 1'b1;
            end else if (c == 2 * (ON_C + OFF_C) + 2) begin
                Start_Play = 1'b1;
            end else begin
                Start_Play = 1'b0;
            end
            step();
            check_next("latch");
        end
        Start_Play = 1'b0;
        push_rec(3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        step();
        check_next("latch_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
